// File: rtl/logic_unit_iter.sv
`default_nettype none
// ============================================================================
//  Module      : logic_unit_iter
//  Description : Multi-cycle bitwise logic unit (AND/OR/XOR/NOR) on two
//                WIDTH-bit operands. It handles SLICE bits per clock, LSB
//                slice first, and uses a start/busy/done handshake. Raises a
//                zero flag with each result.
//                Optional macro LOGIC_PARITY_EN adds a parity output that is
//                accumulated slice by slice.
//  Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
`ifdef LOGIC_PARITY_EN
    output logic             zero,
    output logic             parity
`else
    output logic             zero
`endif
);

    localparam int C_NSLICE = WIDTH / SLICE;
    localparam int C_IDXW   = (C_NSLICE > 1) ? $clog2(C_NSLICE) : 1;

    // A slice size that does not tile the operand width cannot be built.
    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_slice
            $error("logic_unit_iter: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                            state_q, state_d;
    logic [C_NSLICE-1:0][SLICE-1:0]    a_q, a_d;
    logic [C_NSLICE-1:0][SLICE-1:0]    b_q, b_d;
    logic [C_NSLICE-1:0][SLICE-1:0]    acc_q, acc_d;
    logic [1:0]                        op_q, op_d;
    logic [C_IDXW-1:0]                 idx_q, idx_d;
    logic [WIDTH-1:0]                  out_q, out_d;
    logic                              zero_q, zero_d;
`ifdef LOGIC_PARITY_EN
    logic                              par_acc_q, par_acc_d;
    logic                              parity_q, parity_d;
`endif

    logic [SLICE-1:0]                  w_sa;
    logic [SLICE-1:0]                  w_sb;
    logic [SLICE-1:0]                  w_res;
    logic                              w_last;

    // Select the current slice of the latched operands and apply the operation.
    always_comb begin
        w_sa = '0;
        w_sb = '0;
        for (int s = 0; s < C_NSLICE; s++) begin
            if (int'(idx_q) == s) begin
                w_sa = a_q[s];
                w_sb = b_q[s];
            end
        end
        case (op_q)
            2'b00:   w_res = w_sa & w_sb;
            2'b01:   w_res = w_sa | w_sb;
            2'b10:   w_res = w_sa ^ w_sb;
            default: w_res = ~(w_sa | w_sb);
        endcase
        w_last = (int'(idx_q) == (C_NSLICE - 1));
    end

    // Next-state logic: sequence the FSM, fill the accumulator and publish results.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        out_d   = out_q;
        zero_d  = zero_q;
`ifdef LOGIC_PARITY_EN
        par_acc_d = par_acc_q;
        parity_d  = parity_q;
`endif
        case (state_q)
            ST_RUN: begin
                for (int s = 0; s < C_NSLICE; s++) begin
                    if (int'(idx_q) == s) begin
                        acc_d[s] = w_res;
                    end
                end
`ifdef LOGIC_PARITY_EN
                par_acc_d = par_acc_q ^ (^w_res);
`endif
                if (w_last) begin
                    // The result includes the slice written on this same edge.
                    state_d = ST_DONE;
                    idx_d   = '0;
                    out_d   = acc_d;
                    zero_d  = (acc_d == '0);
`ifdef LOGIC_PARITY_EN
                    parity_d = par_acc_d;
`endif
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request; DONE allows back-to-back.
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = in1;
                    b_d     = in2;
                    op_d    = op;
                    acc_d   = '0;
                    idx_d   = '0;
`ifdef LOGIC_PARITY_EN
                    par_acc_d = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
`ifdef LOGIC_PARITY_EN
            par_acc_q <= 1'b0;
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
`ifdef LOGIC_PARITY_EN
            par_acc_q <= par_acc_d;
            parity_q  <= parity_d;
`endif
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);
    assign out  = out_q;
    assign zero = zero_q;
`ifdef LOGIC_PARITY_EN
    assign parity = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_unit_iter
//  Description : Self-checking bench for logic_unit_iter (32/8 and 16/16).
//                Parity checks are active when LOGIC_PARITY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_iter;

    localparam int C_LAT = 5;   // 32/8: done appears NSLICE+1 cycles after start

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] in1, in2;
    logic        busy, done, zero;
    logic [31:0] out;
    logic        start16;
    logic [1:0]  op16;
    logic [15:0] a16, b16;
    logic        busy16, done16, zero16;
    logic [15:0] out16;
`ifdef LOGIC_PARITY_EN
    logic        parity, parity16;
`endif

    int checks = 0;
    int errors = 0;

    logic_unit_iter #(.WIDTH(32), .SLICE(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .in1(in1), .in2(in2),
        .busy(busy), .done(done), .out(out),
`ifdef LOGIC_PARITY_EN
        .zero(zero), .parity(parity)
`else
        .zero(zero)
`endif
    );

    logic_unit_iter #(.WIDTH(16), .SLICE(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .op(op16), .in1(a16), .in2(b16),
        .busy(busy16), .done(done16), .out(out16),
`ifdef LOGIC_PARITY_EN
        .zero(zero16), .parity(parity16)
`else
        .zero(zero16)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-level reference for the four operations.
    function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Issue one request (start high for one cycle) and wait for done; lat=-1 on timeout.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output int lat);
        @(posedge clk); #1;
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        int ndone;
        #2;
        checks++;
        if ({busy, done, zero, out} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b zero=%b out=%h, required all 0", busy, done, zero, out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(2'b10, 32'h0000_00FF, 32'h0000_0000, lat);
        checks++;
        if (out !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL reset_preload: out=%h required 000000ff", out);
        end
        // New op, then reset during its cycle 2.
        @(posedge clk); #1;
        start = 1'b1; op = 2'b01; in1 = 32'h1234_5678; in2 = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, zero, out} !== 35'd0) begin
            errors++;
            $display("FAIL reset_mid_run: busy=%b done=%b zero=%b out=%h, required all 0", busy, done, zero, out);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL reset_no_done: active cycles after reset=%0d required 0", ndone);
        end
    endtask

    task automatic test_xor();
        int lat;
        run_op(2'b10, 32'hF0F0_1234, 32'h0FF0_FFFF, lat);
        checks++;
        if (lat !== C_LAT || out !== 32'hFF00_EDCB || zero !== 1'b0) begin
            errors++;
            $display("FAIL xor_vector: lat=%0d out=%h zero=%b, required lat=5 out=ff00edcb zero=0", lat, out, zero);
        end
`ifdef LOGIC_PARITY_EN
        checks++;
        if (parity !== 1'b1) begin
            errors++;
            $display("FAIL xor_parity: parity=%b required 1", parity);
        end
`endif
    endtask

    task automatic test_and();
        int lat;
        run_op(2'b00, 32'hAAAA_AAAA, 32'h5555_5555, lat);
        checks++;
        if (lat !== C_LAT || out !== 32'h0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL and_zero: lat=%0d out=%h zero=%b, required lat=5 out=00000000 zero=1", lat, out, zero);
        end
`ifdef LOGIC_PARITY_EN
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL and_parity: parity=%b required 0", parity);
        end
`endif
    endtask

    task automatic test_nor();
        logic exp_busy;
        logic exp_done;
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; in1 = 32'h0; in2 = 32'h0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL nor_busy_c0: busy=%b required 0", busy);
        end
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            exp_busy = (c >= 1 && c <= 4);
            exp_done = (c == 5);
            checks++;
            if (busy !== exp_busy || done !== exp_done) begin
                errors++;
                $display("FAIL nor_busy_c%0d: busy=%b done=%b, required busy=%b done=%b", c, busy, done, exp_busy, exp_done);
            end
        end
        checks++;
        if (out !== 32'hFFFF_FFFF || zero !== 1'b0) begin
            errors++;
            $display("FAIL nor_result: out=%h zero=%b, required ffffffff 0", out, zero);
        end
`ifdef LOGIC_PARITY_EN
        checks++;
        if (parity !== 1'b0) begin
            errors++;
            $display("FAIL nor_parity: parity=%b required 0", parity);
        end
`endif
    endtask

    task automatic test_handshake();
        logic [31:0] exp1, exp2;
        exp1 = ref_op(2'b10, 32'hDEAD_BEEF, 32'h0F0F_0F0F);
        exp2 = ref_op(2'b01, 32'h1200_0034, 32'h0056_7800);
        @(posedge clk); #1;
        start = 1'b1; op = 2'b10; in1 = 32'hDEAD_BEEF; in2 = 32'h0F0F_0F0F;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (c == 2) begin
                // Ignored request with different operands during RUN.
                start = 1'b1; op = 2'b00; in1 = 32'hFFFF_FFFF; in2 = 32'h1111_1111;
            end
            if (c == 5) begin
                checks++;
                if (done !== 1'b1 || out !== exp1) begin
                    errors++;
                    $display("FAIL hs_first: done=%b out=%h, required done=1 out=%h", done, out, exp1);
                end
                start = 1'b1; op = 2'b01; in1 = 32'h1200_0034; in2 = 32'h0056_7800;
            end
            if (c >= 6 && c <= 9) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || out !== exp1) begin
                    errors++;
                    $display("FAIL hs_run_c%0d: busy=%b done=%b out=%h, required 1 0 %h", c, busy, done, out, exp1);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL hs_ignore_c%0d: busy=%b done=%b, required 1 0", c, busy, done);
                end
            end
            if (c == 10) begin
                checks++;
                if (done !== 1'b1 || out !== exp2) begin
                    errors++;
                    $display("FAIL hs_second: done=%b out=%h, required done=1 out=%h", done, out, exp2);
                end
            end
        end
    endtask

    task automatic test_random();
        int lat;
        logic [1:0]  o;
        logic [31:0] a, b, e;
        for (int n = 0; n < 20; n++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            if (n % 5 == 0) b = ~a;
            e = ref_op(o, a, b);
            run_op(o, a, b, lat);
            checks++;
            if (lat !== C_LAT || out !== e || zero !== (e == 32'h0)) begin
                errors++;
                $display("FAIL random_%0d: op=%0d lat=%0d out=%h zero=%b, required lat=5 out=%h zero=%b", n, o, lat, out, zero, e, (e == 32'h0));
            end
`ifdef LOGIC_PARITY_EN
            checks++;
            if (parity !== ^e) begin
                errors++;
                $display("FAIL random_parity_%0d: parity=%b required %b", n, parity, ^e);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  ops[6];
        logic [31:0] as[6], bs[6];
        int k;
        int cyc;
        for (int i = 0; i < 6; i++) begin
            ops[i] = 2'($urandom_range(0, 3));
            as[i]  = $urandom;
            bs[i]  = $urandom;
        end
        @(posedge clk); #1;
        start = 1'b1; op = ops[0]; in1 = as[0]; in2 = bs[0];
        k = 0;
        cyc = 0;
        while (k < 6 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) begin
                checks++;
                if (cyc !== C_LAT * (k + 1) || out !== ref_op(ops[k], as[k], bs[k])) begin
                    errors++;
                    $display("FAIL b2b_%0d: cycle=%0d out=%h, required cycle=%0d out=%h", k, cyc, out, C_LAT * (k + 1), ref_op(ops[k], as[k], bs[k]));
                end
                k++;
                if (k < 6) begin
                    op = ops[k]; in1 = as[k]; in2 = bs[k];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (k !== 6) begin
            errors++;
            $display("FAIL b2b_timeout: results=%0d required 6", k);
        end
    endtask

    task automatic test_single_slice();
        int lat;
        logic [15:0] a, b, e;
        for (int n = 0; n < 4; n++) begin
            if (n == 0) begin
                op16 = 2'b01; a = 16'h00F0; b = 16'h0F00;
            end else begin
                op16 = 2'($urandom_range(0, 3)); a = 16'($urandom); b = 16'($urandom);
            end
            e = 16'(ref_op(op16, {16'h0, a}, {16'h0, b}));
            @(posedge clk); #1;
            start16 = 1'b1; a16 = a; b16 = b;
            @(posedge clk); #1;
            start16 = 1'b0;
            lat = 1;
            while (done16 !== 1'b1 && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            checks++;
            if (lat !== 2 || done16 !== 1'b1 || out16 !== e || zero16 !== (e == 16'h0)) begin
                errors++;
                $display("FAIL slice16_%0d: lat=%0d done=%b out=%h zero=%b, required lat=2 done=1 out=%h zero=%b", n, lat, done16, out16, zero16, e, (e == 16'h0));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; op = 2'b00; in1 = '0; in2 = '0;
        start16 = 1'b0; op16 = 2'b00; a16 = '0; b16 = '0;
        test_reset();
        test_xor();
        test_and();
        test_nor();
        test_handshake();
        test_random();
        test_back_to_back();
        test_single_slice();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
